dual_phase_update_sequencer: RTL and testbench

- Synthesizable controller that sequences the delayed two-phase register update pattern used by the concurrent-assertion tests: capture q from d1 after a fixed delay, wait for a phase event, capture q1 from !d1 after a second delay, then issue a sampled "q != d" check strobe.
- Replaces `#` delays and the mid-block event control with counters and an explicit phase input. The check is therefore driven by a well-defined clocked strobe rather than an uninferred clock.
- Sits between stimulus (start, d, d1, phase_evt) and the assertion/checker logic.

---
 rtl/dual_phase_update_sequencer.sv | 160 ++++++++++++++++
 tb/tb_dual_phase_update_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_phase_update_sequencer.sv
// Two-phase delayed register update sequencer: q <- d1 after DELAY1, wait for a
// phase event, q1 <- !d1 after DELAY2, then a one-cycle registered "q != d" check strobe.
module dual_phase_update_sequencer #(
    parameter int DELAY1     = 10,
    parameter int DELAY2     = 10,
    parameter int PH_TIMEOUT = 64,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 4
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             phase_evt,
    input  logic             d,
    input  logic             d1,
    output logic             busy,
    output logic             q,
    output logic             q1,
    output logic             chk_valid,
    output logic             chk_fail,
    output logic             done,
    output logic             timeout_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {IDLE, WAIT1, WAIT_PH, WAIT2, CHECK} state_t;

    localparam logic [CNT_W-1:0] DLY1_LD = CNT_W'(DELAY1);
    localparam logic [CNT_W-1:0] DLY2_LD = CNT_W'(DELAY2);
    localparam logic [CNT_W-1:0] PHTO_LD = CNT_W'(PH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             d1_lat_q, d1_lat_d;
    logic             q_q, q_d;
    logic             q1_q, q1_d;
    logic             busy_q, busy_d;
    logic             chk_valid_q, chk_valid_d;
    logic             chk_fail_q, chk_fail_d;
    logic             done_q, done_d;
    logic             timeout_err_q, timeout_err_d;
    logic             match;

    assign match = (q_q == d);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_count_d   = err_count_q;
        d1_lat_d      = d1_lat_q;
        q_d           = q_q;
        q1_d          = q1_q;
        chk_valid_d   = 1'b0;
        chk_fail_d    = 1'b0;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d1_lat_d = d1;
                    cnt_d    = DLY1_LD;
                    state_d  = WAIT1;
                end
            end
            WAIT1: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    q_d     = d1_lat_q;
                    cnt_d   = PHTO_LD;
                    state_d = WAIT_PH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_PH: begin
                // A phase event arriving on the final timeout cycle still wins.
                if (abort) begin
                    state_d = IDLE;
                end else if (phase_evt) begin
                    cnt_d   = DLY2_LD;
                    state_d = WAIT2;
                end else if (cnt_q == CNT_ONE) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT2: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    // Strobes are registered here so they are high throughout CHECK.
                    q1_d        = ~d1_lat_q;
                    chk_valid_d = 1'b1;
                    done_d      = 1'b1;
                    chk_fail_d  = match;
                    if (match && (err_count_q != ERR_MAX)) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            err_count_q   <= '0;
            d1_lat_q      <= 1'b0;
            q_q           <= 1'b0;
            q1_q          <= 1'b0;
            busy_q        <= 1'b0;
            chk_valid_q   <= 1'b0;
            chk_fail_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_count_q   <= err_count_d;
            d1_lat_q      <= d1_lat_d;
            q_q           <= q_d;
            q1_q          <= q1_d;
            busy_q        <= busy_d;
            chk_valid_q   <= chk_valid_d;
            chk_fail_q    <= chk_fail_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = busy_q;
    assign q           = q_q;
    assign q1          = q1_q;
    assign chk_valid   = chk_valid_q;
    assign chk_fail    = chk_fail_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_dual_phase_update_sequencer.sv
// Directed testbench for dual_phase_update_sequencer; inputs driven and outputs
// sampled on the falling edge, k counts rising edges after start acceptance (T0).
module tb_dual_phase_update_sequencer;

    localparam int D1  = 10;
    localparam int D2  = 10;
    localparam int PTO = 64;

    logic       mclk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, abort = 1'b0, phase_evt = 1'b0, d = 1'b0, d1 = 1'b0;
    logic       busy, q, q1, chk_valid, chk_fail, done, timeout_err;
    logic [3:0] err_count;

    int vec_cnt = 0;
    int err_cnt = 0;
    int r_valid, r_done, r_fail, r_valid_k;

    always #5 mclk = ~mclk;

    dual_phase_update_sequencer #(
        .DELAY1(D1), .DELAY2(D2), .PH_TIMEOUT(PTO), .CNT_W(8), .ERR_W(4)
    ) dut (
        .mclk(mclk), .rst(rst), .start(start), .abort(abort), .phase_evt(phase_evt),
        .d(d), .d1(d1), .busy(busy), .q(q), .q1(q1), .chk_valid(chk_valid),
        .chk_fail(chk_fail), .done(done), .timeout_err(timeout_err), .err_count(err_count)
    );

    task automatic step();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    // Full sequence with the phase event at edge ph_k; records strobe activity.
    task automatic run_seq(input logic d1v, input logic dv, input int ph_k);
        r_valid = 0; r_done = 0; r_fail = 0; r_valid_k = -1;
        d1 = d1v; d = dv; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= ph_k + D2 + 2; k++) begin
            phase_evt = (k == ph_k);
            step();
            if (chk_valid) begin r_valid++; r_valid_k = k; end
            if (done) r_done++;
            if (chk_fail) r_fail++;
        end
        phase_evt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        vec_cnt++;
        if ({busy, q, q1, chk_valid, chk_fail, done, timeout_err, err_count} !== 11'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b want %b",
                     {busy, q, q1, chk_valid, chk_fail, done, timeout_err, err_count}, 11'b0);
        end
        rst = 1'b0;
        step();
        vec_cnt++;
        if ({busy, q, q1, chk_valid, done} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_idle: got %b want %b", {busy, q, q1, chk_valid, done}, 5'b0);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [5:0] exp_v, got_v;
        d1 = 1'b1; d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_accept_busy: got %b want 1", busy);
        end
        for (int k = 1; k <= 25; k++) begin
            phase_evt = (k == 13);
            step();
            // busy, q, q1, chk_valid, chk_fail, done
            exp_v = {(k <= 23), (k >= 10), 1'b0, (k == 23), 1'b0, (k == 23)};
            got_v = {busy, q, q1, chk_valid, chk_fail, done};
            vec_cnt++;
            if (got_v !== exp_v) begin
                err_cnt++;
                $display("FAIL basic_k%0d: got %b want %b", k, got_v, exp_v);
            end
        end
        phase_evt = 1'b0;
        vec_cnt++;
        if (err_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL basic_err_count: got %0d want 0", err_count);
        end
        $display("test_basic done");
    endtask

    task automatic test_err_saturate();
        int exp_err;
        for (int i = 1; i <= 20; i++) begin
            run_seq(1'b1, 1'b1, 13);
            exp_err = (i > 15) ? 15 : i;
            vec_cnt++;
            if (r_fail !== 1 || r_valid !== 1 || r_valid_k !== 23) begin
                err_cnt++;
                $display("FAIL sat_strobe_run%0d: got fail=%0d valid=%0d at k=%0d want 1 1 at 23",
                         i, r_fail, r_valid, r_valid_k);
            end
            vec_cnt++;
            if (err_count !== 4'(exp_err)) begin
                err_cnt++;
                $display("FAIL sat_err_count_run%0d: got %0d want %0d", i, err_count, exp_err);
            end
            $display("run %0d err_count=%0d", i, err_count);
        end
    endtask

    task automatic test_min_length();
        run_seq(1'b0, 1'b1, D1 + 1);
        vec_cnt++;
        if (r_valid_k !== D1 + 1 + D2 || r_done !== 1 || r_fail !== 0) begin
            err_cnt++;
            $display("FAIL minlen_strobe: got k=%0d done=%0d fail=%0d want k=%0d 1 0",
                     r_valid_k, r_done, r_fail, D1 + 1 + D2);
        end
        vec_cnt++;
        if ({q, q1, err_count} !== {1'b0, 1'b1, 4'd15}) begin
            err_cnt++;
            $display("FAIL minlen_regs: got %b want %b", {q, q1, err_count}, {1'b0, 1'b1, 4'd15});
        end
        $display("test_min_length done");
    endtask

    task automatic test_timeout();
        logic [2:0] exp_v, got_v;
        d1 = 1'b1; d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= D1 + PTO + 2; k++) begin
            phase_evt = (k == D1);
            step();
            exp_v = {(k < D1 + PTO), (k >= D1 + PTO), 1'b0};
            got_v = {busy, timeout_err, chk_valid | done};
            vec_cnt++;
            if (got_v !== exp_v) begin
                err_cnt++;
                $display("FAIL timeout_k%0d: got %b want %b", k, got_v, exp_v);
            end
        end
        phase_evt = 1'b0;
        vec_cnt++;
        if ({q, q1} !== 2'b11) begin
            err_cnt++;
            $display("FAIL timeout_regs: got %b want 11", {q, q1});
        end
        $display("test_timeout done");
    endtask

    task automatic test_abort();
        int n_done = 0;
        d1 = 1'b1; d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            phase_evt = (k == 13);
            abort = (k == 18);
            step();
            vec_cnt++;
            if ({busy, done} !== {(k < 18), 1'b0}) begin
                err_cnt++;
                $display("FAIL abort_k%0d: got %b want %b", k, {busy, done}, {(k < 18), 1'b0});
            end
        end
        phase_evt = 1'b0; abort = 1'b0;
        vec_cnt++;
        if ({q, q1} !== 2'b11) begin
            err_cnt++;
            $display("FAIL abort_regs: got %b want 11", {q, q1});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_restart: got busy=%b want 1", busy);
        end
        for (int k = 1; k <= D1 + D2 + 3; k++) begin
            phase_evt = (k == D1 + 1);
            step();
            if (done) n_done++;
        end
        phase_evt = 1'b0;
        vec_cnt++;
        if (n_done !== 1 || q1 !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_restart_done: got done=%0d q1=%b want 1 0", n_done, q1);
        end
        $display("test_abort done");
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        logic eb, ed;
        d1 = 1'b1; d = 1'b0; start = 1'b1; phase_evt = 1'b1;
        step();
        // Minimum period: 21 edges to CHECK, 1 back to IDLE, 1 to accept again.
        for (int k = 1; k <= 68; k++) begin
            step();
            eb = ((k % 23) != 22);
            ed = ((k % 23) == 21);
            if (done) n_done++;
            vec_cnt++;
            if ({busy, done, chk_valid} !== {eb, ed, ed}) begin
                err_cnt++;
                $display("FAIL b2b_k%0d: got %b want %b", k, {busy, done, chk_valid}, {eb, ed, ed});
            end
        end
        start = 1'b0; phase_evt = 1'b0;
        step();
        vec_cnt++;
        if (n_done !== 3 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_count: got done=%0d busy=%b want 3 0", n_done, busy);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        d1 = 1'b1; d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        vec_cnt++;
        if ({busy, q, timeout_err, err_count} !== {1'b1, 1'b1, 1'b1, 4'd15}) begin
            err_cnt++;
            $display("FAIL rstmid_pre: got %b want %b", {busy, q, timeout_err, err_count},
                     {1'b1, 1'b1, 1'b1, 4'd15});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec_cnt++;
        if ({busy, q, q1, chk_valid, chk_fail, done, timeout_err, err_count} !== 11'b0) begin
            err_cnt++;
            $display("FAIL rstmid_outputs: got %b want %b",
                     {busy, q, q1, chk_valid, chk_fail, done, timeout_err, err_count}, 11'b0);
        end
        for (int k = 1; k <= D1 + 5; k++) step();
        vec_cnt++;
        if ({busy, q} !== 2'b00) begin
            err_cnt++;
            $display("FAIL rstmid_no_partial: got %b want 00", {busy, q});
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge mclk);
        test_reset();
        test_basic();
        test_err_saturate();
        test_min_length();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
